// File: rtl/game_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_session_ctrl
// Brief    : Melody-game session sequencer: clear, pattern load, start, and
//            debounced keypad forwarding with end-of-game / timeout close.
// Revision : 1.0 - initial release
// ============================================================================
module game_session_ctrl #(
    parameter logic [31:0] SEED         = 32'hACE1_2024,
    parameter int          DEBOUNCE_CYC = 250000,
    parameter int          TIMEOUT_CYC  = 1500000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic [3:0]  key_raw,
    input  logic        game_end_in,
    output logic        game_rst,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        game_start,
    output logic [3:0]  keypad_out,
    output logic        keypad_enable,
    output logic        session_active,
    output logic        session_done,
    output logic        timed_out,
    output logic [7:0]  press_count
);

    localparam logic [31:0] c_SEED      = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] c_NOTE_MASK = 32'h7777_7777;
    localparam int          c_DB_W      = $clog2(DEBOUNCE_CYC + 1);
    localparam int          c_TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_DB_W-1:0] c_DB_FULL = c_DB_W'(DEBOUNCE_CYC);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_ARM  = 3'd3,
        S_PLAY = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_start_s1, r_start_s2, r_start_q, r_start_evt;
    logic [3:0]        r_key_s1, r_key_s2;
    logic [31:0]       r_lfsr;
    logic [3:0]        r_db_level;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_db_armed;
    logic [c_TO_W-1:0] r_to_cnt;

    logic w_db_stable, w_db_hit, w_press, w_fwd, w_to_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_s1  <= 1'b0;
            r_start_s2  <= 1'b0;
            r_start_q   <= 1'b0;
            r_start_evt <= 1'b0;
            r_key_s1    <= 4'd0;
            r_key_s2    <= 4'd0;
            r_lfsr      <= c_SEED;
        end else begin
            r_start_s1  <= start_btn;
            r_start_s2  <= r_start_s1;
            r_start_q   <= r_start_s2;
            r_start_evt <= r_start_s2 & ~r_start_q;
            r_key_s1    <= key_raw;
            r_key_s2    <= r_key_s1;
            r_lfsr      <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 32'h0);
        end
    end

    // The counter saturates at DEBOUNCE_CYC so each stable period hits exactly once.
    assign w_db_stable = (r_key_s2 == r_db_level);
    assign w_db_hit    = w_db_stable && (r_db_cnt == c_DB_LAST);
    assign w_press     = w_db_hit && (r_db_level != 4'd0) && r_db_armed;
    assign w_fwd       = w_press && (r_state == S_PLAY) && (r_db_level <= 4'd8);
    assign w_to_expire = (r_state == S_PLAY) && (r_to_cnt == c_TO_LAST)
                         && !w_fwd && !game_end_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_level <= 4'd0;
            r_db_cnt   <= '0;
            r_db_armed <= 1'b0;
        end else if (r_state == S_CLR) begin
            r_db_level <= 4'd0;
            r_db_cnt   <= '0;
            r_db_armed <= 1'b0;
        end else if (!w_db_stable) begin
            r_db_level <= r_key_s2;
            r_db_cnt   <= '0;
        end else begin
            if (r_db_cnt != c_DB_FULL) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_db_hit) begin
                r_db_armed <= (r_db_level == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out      <= 32'd0;
            keypad_out    <= 4'd0;
            keypad_enable <= 1'b0;
            press_count   <= 8'd0;
            timed_out     <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            keypad_enable <= w_fwd;
            if (r_state == S_CLR) begin
                data_out    <= r_lfsr & c_NOTE_MASK;
                press_count <= 8'd0;
                timed_out   <= 1'b0;
                r_to_cnt    <= '0;
            end else begin
                if (w_fwd) begin
                    keypad_out <= r_db_level;
                    if (press_count != 8'hFF) begin
                        press_count <= press_count + 8'd1;
                    end
                end
                if (r_state == S_PLAY) begin
                    r_to_cnt <= w_fwd ? '0 : r_to_cnt + 1'b1;
                end
                if (w_to_expire) begin
                    timed_out <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        game_rst       = 1'b0;
        write_enable   = 1'b0;
        game_start     = 1'b0;
        session_active = 1'b0;
        session_done   = 1'b0;
        case (r_state)
            S_IDLE: if (r_start_evt) w_state_nxt = S_CLR;
            S_CLR: begin
                game_rst    = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                write_enable = 1'b1;
                w_state_nxt  = S_ARM;
            end
            S_ARM: begin
                game_start  = 1'b1;
                w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                session_active = 1'b1;
                if (game_end_in || w_to_expire) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                session_done = 1'b1;
                if (r_start_evt) w_state_nxt = S_CLR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/game_session_ctrl.md
# game_session_ctrl

Session sequencer that drives the melody-memory game datapath: it clears the game core, loads a pseudo-random 8-note pattern, starts the game, and forwards debounced keypad presses as single-cycle enables. It watches the core's end-of-game flag and a no-input timeout to close the session. It sits between the board I/O (start button, raw keypad) and the game core's `data_in`/`write_enable`/`game_start`/`keypad_enable` inputs.

## Interface
- `SEED`, 32'hACE1_2024, LFSR reset value; a value of 0 is forced to 32'h0000_0001.
- `DEBOUNCE_CYC`, 250000, clk cycles a raw level must stay stable before it is accepted (≥2).
- `TIMEOUT_CYC`, 1500000000, clk cycles without an accepted press in PLAY before the session aborts.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start_btn`  in  1  raw start button, asynchronous, active-high.
- `key_raw`  in  4  raw keypad code; 0 = no key, 1..8 = notes, 9..15 = invalid.
- `game_end_in`  in  1  end-of-game level from the game core.
- `game_rst`  out  1  one-cycle clear pulse to the game core.
- `data_out`  out  32  pattern to the core; only 3-bit fields, i.e. `lfsr & 32'h7777_7777`.
- `write_enable`  out  1  one-cycle pattern-load strobe.
- `game_start`  out  1  one-cycle start strobe.
- `keypad_out`  out  4  last accepted key code.
- `keypad_enable`  out  1  one-cycle strobe per accepted press.
- `session_active`  out  1  high in PLAY.
- `session_done`  out  1  high in DONE.
- `timed_out`  out  1  set on timeout exit; cleared in CLR.
- `press_count`  out  8  accepted presses this session, saturating at 255.

## Operation
- **Input synchronisation**
  - `start_btn` and `key_raw` each pass through 2-FF synchronisers.
  - Start event = rising edge of the synchronised `start_btn`.
- **LFSR**
  - 32-bit Galois LFSR, right shift, feedback mask 32'h8020_0003.
  - Steps every clk in all states and never reaches 0.
- **States:** IDLE, CLR, LOAD, ARM, PLAY, DONE.
  - IDLE: start event → CLR.
  - CLR:
    - `game_rst`=1 for this cycle only.
    - Clears `press_count`, `timed_out`, the timeout counter and the debouncer.
    - Always → LOAD.
  - LOAD:
    - `data_out` is registered from the LFSR on entry and held until the next LOAD.
    - `write_enable`=1 for this cycle only.
    - Always → ARM.
  - ARM: `game_start`=1 for this cycle only; always → PLAY.
  - PLAY (`session_active`=1):
    - `game_end_in`=1 → DONE.
    - Timeout counter reaching `TIMEOUT_CYC`-1 → DONE with `timed_out`<=1.
    - If both occur in the same cycle, `game_end_in` wins and `timed_out` stays 0.
  - DONE (`session_done`=1): start event → CLR, which starts a new pattern.
- **Debouncer** (active in all states)
  - Tracks the synchronised key level; a change restarts a stability counter.
  - A nonzero level stable for `DEBOUNCE_CYC` cycles counts as a press.
  - A zero level stable for `DEBOUNCE_CYC` cycles arms the next press.
  - Only one press per arm; a held key or a direct key-to-key change produces no second press.
- **Press forwarding**
  - A press is forwarded only in PLAY and only if the code is 1..8.
  - Forwarding:
    - `keypad_out` <= code, `keypad_enable`=1 for one cycle.
    - `press_count` +1, saturating at 255.
    - Timeout counter cleared.
  - Presses outside PLAY or with codes 9..15 are consumed silently: no strobe, no count, no timeout clear.
- The strobes `game_rst`, `write_enable`, `game_start` and `keypad_enable` are mutually exclusive by construction.

## Timing
- **Reset values**
  - State IDLE, LFSR = `SEED` (or 1 if `SEED` is 0), all counters 0.
  - All outputs 0, including `data_out`, `keypad_out` and `press_count`.
- Reset mid-session returns to IDLE immediately with the same values; nothing is held over.
- **Start-to-PLAY latency**
  - Start event is detected 3 cycles after the raw `start_btn` edge (2 sync FFs + edge register).
  - CLR, LOAD and ARM then follow on consecutive cycles; PLAY is entered in the cycle after ARM.
- **Key latency:** raw `key_raw` change → `keypad_enable` = 2 sync cycles + `DEBOUNCE_CYC` + 1 cycle.
- **`game_end_in` → DONE:** 1 cycle (registered state).
- **Timeout:** DONE is entered exactly `TIMEOUT_CYC` cycles after entering PLAY or after the last forwarded press.
- **Same-cycle press and timeout expiry:** the press is forwarded and clears the counter; no timeout occurs.
- Start events in CLR, LOAD, ARM or PLAY are ignored.

## Test plan
1. **Start handshake.** `SEED`=1, `DEBOUNCE_CYC`=4, `TIMEOUT_CYC`=200; pulse `start_btn` → on consecutive cycles `game_rst`, then `write_enable` with `data_out`=`lfsr&32'h77777777`, then `game_start`, each one cycle wide; `session_active`=1 on the following cycle.
2. **Press forwarding.** In PLAY, hold `key_raw`=5 for 10 cycles then release for 10 → exactly one `keypad_enable`, `keypad_out`=5, `press_count`=1. Repeat with code 12 → no strobe, `press_count` stays 1.
3. **Debounce.** Toggle `key_raw` between 3 and 0 every 2 cycles for 40 cycles → no `keypad_enable`.
4. **Timeout.** No presses for 200 cycles → DONE, `timed_out`=1. Then assert `game_end_in` and `start_btn` in the same cycle on another run at cycle 199 → `timed_out`=0.
5. **Game end and restart.** In PLAY, assert `game_end_in` → `session_done`=1 next cycle. A new `start_btn` edge → CLR clears `press_count` to 0, and the new `data_out` differs from the first session's.
6. **Reset mid-session.** Assert `reset` during LOAD → all outputs 0, state IDLE, LFSR = `SEED`.
